// File: rtl/popcnt_seq_pkg.sv
// Shared types and helpers for the popcount sequencer.
// Carry-save cells live here so every row uses the same gate.
package popcnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } popcnt_state_t;

  function automatic int cw_of(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  function automatic int n_of(input int xlen, input int chunk);
    return xlen / chunk;
  endfunction

  // slices covering the low 32 bits (cpopw)
  function automatic int nw_of(input int chunk);
    return (chunk >= 32) ? 1 : 32 / chunk;
  endfunction

  // 3:2 cell: {carry, sum}
  function automatic logic [1:0] csa3(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // 2:2 cell: {carry, sum}
  function automatic logic [1:0] ha22(
    input logic a,
    input logic b
  );
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/popcnt_slice.sv
// Combinational popcount of one slice.
// Recursive halving tree; halves are joined by a ripple of 2:2/3:2 cells.
module popcnt_slice
  import popcnt_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]       bits,
  output logic [$clog2(W):0] cnt
);

  if (W == 1) begin : g_leaf
    assign cnt = bits;
  end else if (W == 2) begin : g_pair
    assign cnt = ha22(bits[0], bits[1]);
  end else begin : g_tree
    localparam int H  = W / 2;
    localparam int HW = $clog2(H) + 1;

    logic [HW-1:0] lo;
    logic [HW-1:0] hi;
    logic [HW:1]   cy;

    popcnt_slice #(.W(H)) u_lo (
      .bits(bits[H-1:0]),
      .cnt (lo)
    );

    popcnt_slice #(.W(H)) u_hi (
      .bits(bits[W-1:H]),
      .cnt (hi)
    );

    // ripple-add the two half counts
    always_comb begin
      cy  = '0;
      cnt = '0;
      {cy[1], cnt[0]} = ha22(lo[0], hi[0]);
      for (int i = 1; i < HW; i++) begin
        {cy[i+1], cnt[i]} = csa3(lo[i], hi[i], cy[i]);
      end
      cnt[HW] = cy[HW];
    end
  end

endmodule

// File: rtl/popcnt_seq.sv
// Multi-cycle popcount: one slice per cycle into a carry-save
// accumulator, a single carry-propagate add, then hold until taken.
module popcnt_seq
  import popcnt_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CHUNK = 8,
  parameter int CW    = cw_of(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            word,
  input  logic [XLEN-1:0] src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   result
);

  localparam int N  = n_of(XLEN, CHUNK);
  localparam int NW = nw_of(CHUNK);
  localparam int KW = $clog2(N);
  localparam int SW = $clog2(CHUNK) + 1;

  localparam logic [KW-1:0] LAST_D = KW'(N - 1);
  localparam logic [KW-1:0] LAST_W = KW'(NW - 1);

  popcnt_state_t   state;
  logic [XLEN-1:0] op;
  logic [KW-1:0]   k;
  logic [KW-1:0]   last;
  logic [CW-1:0]   s;
  logic [CW-1:0]   c;
  logic [CW-1:0]   s_nxt;
  logic [CW-1:0]   maj;
  logic [CW-1:0]   c_nxt;
  logic [CW-1:0]   cnt;
  logic [CHUNK-1:0] slice;
  logic [SW-1:0]   slice_cnt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign slice = op[int'(k)*CHUNK +: CHUNK];

  popcnt_slice #(.W(CHUNK)) u_slice (
    .bits(slice),
    .cnt (slice_cnt)
  );

  assign cnt = CW'(slice_cnt);

  for (genvar i = 0; i < CW; i++) begin : g_csa
    assign {maj[i], s_nxt[i]} = csa3(s[i], c[i], cnt[i]);
  end

  // total never exceeds XLEN, so dropping the top carry is exact
  assign c_nxt = maj << 1;

  // sequencer FSM with operand, accumulator and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op     <= '0;
      k      <= '0;
      last   <= '0;
      s      <= '0;
      c      <= '0;
      result <= '0;
    end else if (flush) begin
      state  <= IDLE;
      k      <= '0;
      s      <= '0;
      c      <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= src;
            k     <= '0;
            last  <= word ? LAST_W : LAST_D;
            s     <= '0;
            c     <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          s <= s_nxt;
          c <= c_nxt;
          k <= k + 1'b1;
          if (k == last) state <= RESOLVE;
        end
        RESOLVE: begin
          result <= s + c;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_seq.sv
// Directed and random checks for popcnt_seq.
// Vector table plus hand-built flush/reset sequences.
module tb_popcnt_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        word = 1'b0;
  logic [63:0] src = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] src;
    logic        word;
    int          stall;
    int          exp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  popcnt_seq #(.XLEN(64), .CHUNK(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .word     (word),
    .src      (src),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // accept one operand at the next edge; return at the negedge after it
  task automatic accept(input logic [63:0] v, input logic w);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", longint'(in_ready), 1);
    src = v;
    word = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [63:0] v, input logic w,
                       input int stall, input int exp_res);
    int lat;
    int exp_lat;
    exp_lat = w ? 5 : 9;
    accept(v, w);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", longint'(lat), longint'(exp_lat));
    chk("result", longint'(result), longint'(exp_res));
    chk("busy_in_ready", longint'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_result", longint'(result), longint'(exp_res));
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_in_ready", longint'(in_ready), 1);
    chk("ret_valid", longint'(out_valid), 0);
  endtask

  initial begin
    logic [63:0] r;
    logic        rw;
    int          seen;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 64};
    vecs[1]  = '{64'h0000_0000_0000_0000, 1'b0, 0, 0};
    vecs[2]  = '{64'h8000_0000_0000_0001, 1'b1, 0, 1};
    vecs[3]  = '{64'h0123_4567_89AB_CDEF, 1'b0, 3, 32};
    vecs[4]  = '{64'h0000_0000_0000_00F0, 1'b0, 0, 4};
    vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 32};
    vecs[6]  = '{64'hFFFF_FFFF_0000_0000, 1'b1, 0, 0};
    vecs[7]  = '{64'h5555_5555_5555_5555, 1'b0, 2, 32};
    vecs[8]  = '{64'h8000_0000_0000_0000, 1'b0, 0, 1};
    vecs[9]  = '{64'h0000_0000_8000_0000, 1'b1, 0, 1};
    vecs[10] = '{64'h0000_0001_0000_0000, 1'b1, 0, 0};
    vecs[11] = '{64'h0F0F_0000_0000_0003, 1'b0, 0, 10};

    #12;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_result", longint'(result), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].src, vecs[i].word, vecs[i].stall, vecs[i].exp);
    end

    // reset while in RESOLVE (word op: 4 ACCUM cycles)
    accept(64'h0000_0000_0000_00FF, 1'b1);
    repeat (4) @(negedge clk);
    chk("resolve_in_ready", longint'(in_ready), 0);
    chk("resolve_valid", longint'(out_valid), 0);
    #1 reset = 1'b0;
    #1;
    chk("areset_in_ready", longint'(in_ready), 1);
    chk("areset_valid", longint'(out_valid), 0);
    chk("areset_result", longint'(result), 0);
    @(negedge clk);
    reset = 1'b1;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 64);

    // flush in the 4th ACCUM cycle
    accept(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", longint'(in_ready), 1);
    chk("flush_result", longint'(result), 0);
    seen = 0;
    repeat (12) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", longint'(seen), 0);
    do_op(64'h0000_0000_0000_00F0, 1'b0, 0, 4);

    // flush in IDLE blocks an accept
    src = 64'hFF;
    word = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_no_accept", longint'(in_ready), 1);

    // flush together with out_ready in DONE
    accept(64'h0000_0000_0000_000F, 1'b1);
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("done_reached", longint'(out_valid), 1);
    chk("done_result", longint'(result), 4);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("done_flush_valid", longint'(out_valid), 0);
    chk("done_flush_result", longint'(result), 0);
    chk("done_flush_in_ready", longint'(in_ready), 1);

    // random back-to-back with backpressure
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      do_op(r, rw, int'($urandom_range(0, 2)),
            rw ? $countones(r[31:0]) : $countones(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/popcnt_seq.md
# popcnt_seq

Multi-cycle population-count sequencer for the bit-manipulation unit. It accepts one XLEN-bit operand under a valid/ready handshake and feeds it CHUNK bits per cycle through a shared 3:2 carry-save compressor row into a carry-save accumulator. It then resolves the sum with one carry-propagate add and holds the count until the consumer takes it. It serves cpop/cpopw where area matters more than latency.

## Interface
- XLEN, 64: operand width; a multiple of CHUNK.
- CHUNK, 8: bits consumed per ACCUM cycle; a power of two, at most XLEN/2.
- CW, $clog2(XLEN)+1: result and accumulator width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  operand presented.
- in_ready  output  1  sequencer can accept an operand.
- word  input  1  count only bits [31:0] (cpopw); sampled with the operand.
- src  input  XLEN  operand.
- flush  input  1  synchronous abort of any operation in flight.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  CW  population count, zero-extended.

## Operation
- States:
  - IDLE: in_ready=1.
  - ACCUM: one slice per cycle.
  - RESOLVE: carry-propagate add.
  - DONE: out_valid=1.
- IDLE -> ACCUM on accept (in_valid & in_ready & ~flush).
  - Latch src into an operand register and set slice index k=0.
  - Set the last index: N-1, where N=XLEN/CHUNK, or N=32/CHUNK when word=1.
  - Clear accumulators S=0 and C=0.
- ACCUM, each cycle:
  - cnt = number of ones in operand bits [k*CHUNK +: CHUNK], zero-extended to CW.
  - S' = S ^ C ^ cnt.
  - C' = majority(S,C,cnt) << 1, truncated to CW. The truncation is exact because the true total is at most XLEN.
  - k increments. ACCUM -> RESOLVE after the slice with k = last index.
- RESOLVE: result register <= S + C (CW bits). -> DONE.
- DONE: hold result and out_valid=1 until out_ready=1, then -> IDLE.
- flush=1 in any state -> IDLE on the next edge:
  - out_valid drops.
  - The result register clears to 0.
  - No accept occurs in that cycle, even if in_valid=1 in IDLE.
- The operand register is not cleared by flush; it is don't-care in IDLE.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1.
  - out_valid=0, result=0, S=C=0, k=0.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Latency: an operand accepted at edge t gives out_valid=1 after edge t+N+1.
  - 9 cycles for XLEN=64, CHUNK=8, word=0.
  - 5 cycles for word=1.
- Throughput:
  - One operation per N+3 cycles with out_ready tied high (accept, N ACCUM, RESOLVE, DONE).
  - No new accept is possible until the cycle after DONE exits.
- out_valid, once high, stays high with result stable until out_ready=1 or flush=1.
- reset asserted mid-operation forces the reset values immediately (asynchronously). The first accept is possible on the first edge after deassertion.
- flush and out_ready high together in DONE: the flush behaviour applies (result clears to 0). The handshake still completes.

## Structure
- Shared bmu package holds:
  - the state enum popcnt_state_t (IDLE, ACCUM, RESOLVE, DONE);
  - the localparam derivation of CW and N.
- Sub-module popcnt_slice (CHUNK in, $clog2(CHUNK)+1 out) counts one slice as a combinational tree of 3:2 and 2:2 compressor cells.
- The accumulator row is CW instances of the existing 3:2 carry-save cell.
- The top holds:
  - the FSM;
  - the slice index counter;
  - the operand, S, C and result registers;
  - the final adder.

## Test plan
- src=64'hFFFF_FFFF_FFFF_FFFF, word=0, out_ready=1 -> out_valid after 9 cycles with result=64, then in_ready=1 the next cycle.
- src=0 -> result=0. Then src=64'h8000_0000_0000_0001 with word=1 -> result=1 after 5 cycles, because bit 63 is ignored.
- src=64'h0123_4567_89AB_CDEF, out_ready held low 3 cycles -> result=32 stable for all cycles out_valid=1, and in_ready=0 throughout.
- Accept src=all ones, assert flush in the 4th ACCUM cycle -> out_valid never rises, in_ready=1 the next cycle. A following src=64'hF0 returns result=4.
- Assert reset in RESOLVE -> out_valid=0, result=0 and in_ready=1 immediately. The first post-reset operand counts correctly.
- Random operands (both word values) checked back-to-back against $countones, with random out_ready backpressure.
